// File: rtl/sync_pulse_gen.sv
// rtl/sync_pulse_gen.sv - trigger-to-pulse delay/width/hold-off sequencer
// Synchronizes trig, waits drt cycles, emits a width-cycle pulse, then holds off HOLDOFF cycles.
module sync_pulse_gen #(
  parameter int HOLDOFF = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk_gen,
  input  logic             rst,
  input  logic             en,
  input  logic             trig,
  input  logic [CNT_W-1:0] drt,
  input  logic [7:0]       width,
  output logic             pulse,
  output logic             busy,
  output logic             done,
  output logic             missed
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : '0;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [7:0]       w_lat;
  logic [7:0]       w_lat_n;
  logic [7:0]       w_sel;
  logic             done_n;
  logic             pulse_n;
  logic             enter_pulse;
  logic             enter_finish;
  logic             s1;
  logic             s2;
  logic             s3;
  logic             trig_edge;

  // s1/s2 resolve metastability; s3 only delays s2 for edge detection.
  always_ff @(posedge clk_gen or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= trig;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign trig_edge = s2 & ~s3;

  always_ff @(posedge clk_gen or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      w_lat  <= '0;
      pulse  <= 1'b0;
      done   <= 1'b0;
      missed <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      w_lat  <= w_lat_n;
      pulse  <= pulse_n;
      done   <= done_n;
      missed <= missed | (trig_edge & (state != IDLE));
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    w_lat_n      = w_lat;
    w_sel        = w_lat;
    done_n       = 1'b0;
    enter_pulse  = 1'b0;
    enter_finish = 1'b0;

    case (state)
      IDLE: begin
        if (trig_edge) begin
          w_lat_n = width;
          w_sel   = width;
          if (drt != '0) begin
            state_n = DELAY;
            cnt_n   = drt - ONE;
          end else begin
            enter_pulse = 1'b1;
          end
        end
      end
      DELAY: begin
        if (cnt == '0) enter_pulse = 1'b1;
        else           cnt_n = cnt - ONE;
      end
      PULSE: begin
        if (cnt == '0) enter_finish = 1'b1;
        else           cnt_n = cnt - ONE;
      end
      HOLD: begin
        if (cnt == '0) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt - ONE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // A zero width skips the pulse entirely and falls through to hold-off.
    if (enter_pulse) begin
      if (w_sel != 8'd0) begin
        state_n = PULSE;
        cnt_n   = CNT_W'(w_sel - 8'd1);
      end else begin
        enter_finish = 1'b1;
      end
    end

    if (enter_finish) begin
      if (HOLDOFF == 0) begin
        state_n = IDLE;
        cnt_n   = '0;
        done_n  = 1'b1;
      end else begin
        state_n = HOLD;
        cnt_n   = HOLD_LOAD;
      end
    end

    // Disable aborts silently: no done, counter parked at zero.
    if (!en) begin
      state_n = IDLE;
      cnt_n   = '0;
      done_n  = 1'b0;
    end

    pulse_n = (state_n == PULSE);
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sync_pulse_gen.sv
// tb/tb_sync_pulse_gen.sv - self-checking bench for sync_pulse_gen
// Expected outputs come from interval arithmetic on trigger time, delay, width and hold-off.
module tb_sync_pulse_gen;

  localparam int H = 16;

  logic        clk_gen = 1'b0;
  logic        rst;
  logic        en;
  logic        trig;
  logic [31:0] drt;
  logic [7:0]  width;
  logic        pulse;
  logic        busy;
  logic        done;
  logic        missed;

  int n_cmp = 0;
  int n_bad = 0;
  logic m_model = 1'b0;

  sync_pulse_gen #(.HOLDOFF(H), .CNT_W(32)) dut (
    .clk_gen(clk_gen),
    .rst(rst),
    .en(en),
    .trig(trig),
    .drt(drt),
    .width(width),
    .pulse(pulse),
    .busy(busy),
    .done(done),
    .missed(missed)
  );

  always #5 clk_gen = ~clk_gen;

  // Outputs after edge E0+k for a sequence triggered at E0: {pulse, busy, done, missed}.
  function automatic logic [3:0] model_out(int k, int d, int w, logic m);
    int t;
    int pe;
    int be;
    logic p;
    logic b;
    logic dn;
    t  = 2;
    pe = t + d + w;
    be = pe + H;
    p  = (k >= t + d) && (k < pe);
    b  = (k >= t) && (k < be);
    dn = (k == be);
    return {p, b, dn, m};
  endfunction

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk_gen);
    trig = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    #1;
    obs = {pulse, busy, done, missed};
    n_cmp++;
    if (obs !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_async got=%b exp=0000", obs);
    end
    repeat (2) @(posedge clk_gen);
    #1;
    obs = {pulse, busy, done, missed};
    n_cmp++;
    if (obs !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_held got=%b exp=0000", obs);
    end
    @(negedge clk_gen);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_gen);
      #1;
      obs = {pulse, busy, done, missed};
      n_cmp++;
      if (obs !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset_idle k=%0d got=%b exp=0000", k, obs);
      end
    end
  endtask

  task automatic test_basic();
    logic [3:0] obs;
    logic [3:0] exp;
    @(negedge clk_gen);
    drt = 32'd5; width = 8'd3; trig = 1'b1;
    for (int k = 0; k <= 2 + 5 + 3 + H + 3; k++) begin
      @(posedge clk_gen);
      #1;
      if (k == 0) trig = 1'b0;
      if (k == 3) begin
        drt   = $urandom_range(1, 50);
        width = 8'($urandom_range(1, 50));
      end
      obs = {pulse, busy, done, missed};
      exp = model_out(k, 5, 3, 1'b0);
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL basic k=%0d got=%b exp=%b", k, obs, exp);
      end
    end
  endtask

  task automatic test_zero_delay();
    logic [3:0] obs;
    logic [3:0] exp;
    @(negedge clk_gen);
    drt = 32'd0; width = 8'd1; trig = 1'b1;
    for (int k = 0; k <= 2 + 1 + H + 3; k++) begin
      @(posedge clk_gen);
      #1;
      if (k == 1) trig = 1'b0;
      obs = {pulse, busy, done, missed};
      exp = model_out(k, 0, 1, 1'b0);
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL zero_delay k=%0d got=%b exp=%b", k, obs, exp);
      end
    end
  endtask

  task automatic test_zero_width();
    logic [3:0] obs;
    logic [3:0] exp;
    @(negedge clk_gen);
    drt = 32'd4; width = 8'd0; trig = 1'b1;
    for (int k = 0; k <= 2 + 4 + H + 3; k++) begin
      @(posedge clk_gen);
      #1;
      if (k == 0) trig = 1'b0;
      obs = {pulse, busy, done, missed};
      exp = model_out(k, 4, 0, 1'b0);
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL zero_width k=%0d got=%b exp=%b", k, obs, exp);
      end
    end
  endtask

  task automatic test_missed();
    logic [3:0] obs;
    logic [3:0] exp;
    @(negedge clk_gen);
    drt = 32'd100; width = 8'd10; trig = 1'b1;
    for (int k = 0; k <= 2 + 100 + 10 + H + 3; k++) begin
      @(posedge clk_gen);
      #1;
      trig = (k == 19);
      obs = {pulse, busy, done, missed};
      exp = model_out(k, 100, 10, (k >= 22));
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL missed k=%0d got=%b exp=%b", k, obs, exp);
      end
    end
    m_model = 1'b1;
  endtask

  task automatic test_enable_abort();
    logic [3:0] obs;
    logic [3:0] exp;
    @(negedge clk_gen);
    drt = 32'd1000; width = 8'd50; trig = 1'b1;
    for (int k = 0; k <= 1021; k++) begin
      @(posedge clk_gen);
      #1;
      if (k == 0) trig = 1'b0;
      obs = {pulse, busy, done, missed};
      exp = model_out(k, 1000, 50, 1'b1);
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL abort_run k=%0d got=%b exp=%b", k, obs, exp);
      end
    end
    en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk_gen);
      #1;
      trig = (k == 3);
      obs = {pulse, busy, done, missed};
      n_cmp++;
      if (obs !== 4'b0001) begin
        n_bad++;
        $display("FAIL abort_off k=%0d got=%b exp=0001", k, obs);
      end
    end
    idle_cycles(3);
    en = 1'b1;
    idle_cycles(2);
    drt = 32'd3; width = 8'd2; trig = 1'b1;
    for (int k = 0; k <= 2 + 3 + 2 + H + 3; k++) begin
      @(posedge clk_gen);
      #1;
      if (k == 0) trig = 1'b0;
      obs = {pulse, busy, done, missed};
      exp = model_out(k, 3, 2, 1'b1);
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL abort_rearm k=%0d got=%b exp=%b", k, obs, exp);
      end
    end
  endtask

  task automatic test_rst_mid();
    logic [3:0] obs;
    logic [3:0] exp;
    @(negedge clk_gen);
    drt = 32'd200; width = 8'd5; trig = 1'b1;
    for (int k = 0; k <= 50; k++) begin
      @(posedge clk_gen);
      #1;
      if (k == 0) trig = 1'b0;
      obs = {pulse, busy, done, missed};
      exp = model_out(k, 200, 5, 1'b1);
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL rst_pre k=%0d got=%b exp=%b", k, obs, exp);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    obs = {pulse, busy, done, missed};
    n_cmp++;
    if (obs !== 4'b0000) begin
      n_bad++;
      $display("FAIL rst_async got=%b exp=0000", obs);
    end
    repeat (2) @(posedge clk_gen);
    #1;
    obs = {pulse, busy, done, missed};
    n_cmp++;
    if (obs !== 4'b0000) begin
      n_bad++;
      $display("FAIL rst_hold got=%b exp=0000", obs);
    end
    @(negedge clk_gen);
    rst = 1'b0;
    m_model = 1'b0;
    idle_cycles(2);
    drt = 32'd200; width = 8'd5; trig = 1'b1;
    for (int k = 0; k <= 2 + 200 + 5 + H + 3; k++) begin
      @(posedge clk_gen);
      #1;
      if (k == 0) trig = 1'b0;
      obs = {pulse, busy, done, missed};
      exp = model_out(k, 200, 5, 1'b0);
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL rst_retrig k=%0d got=%b exp=%b", k, obs, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] obs;
    logic [3:0] exp;
    int d;
    int w;
    int hi;
    int r;
    int len;
    logic retrig;
    logic m;
    for (int it = 0; it < 16; it++) begin
      d      = $urandom_range(0, 30);
      w      = $urandom_range(0, 20);
      hi     = $urandom_range(1, 3);
      retrig = 1'($urandom_range(0, 1));
      len    = 2 + d + w + H;
      r      = $urandom_range(hi + 2, len - 2);
      idle_cycles(2);
      drt = 32'(d); width = 8'(w); trig = 1'b1;
      for (int k = 0; k <= len + 3; k++) begin
        @(posedge clk_gen);
        #1;
        trig = (k + 1 < hi) || (retrig && (k + 1 == r));
        m    = m_model | (retrig && (k >= r + 2));
        obs  = {pulse, busy, done, missed};
        exp  = model_out(k, d, w, m);
        n_cmp++;
        if (obs !== exp) begin
          n_bad++;
          $display("FAIL random it=%0d d=%0d w=%0d k=%0d got=%b exp=%b", it, d, w, k, obs, exp);
        end
      end
      m_model = m_model | retrig;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; trig = 1'b0; drt = '0; width = '0;
    test_reset();
    idle_cycles(2);
    test_basic();
    idle_cycles(2);
    test_zero_delay();
    idle_cycles(2);
    test_zero_width();
    idle_cycles(2);
    test_missed();
    idle_cycles(2);
    test_enable_abort();
    idle_cycles(2);
    test_rst_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_pulse_gen.md
# sync_pulse_gen

Delay/pulse timing stage that consumes the delay product `drt` and the pulse-width byte `out` produced by the parameter RAM. On each rising edge of an external trigger it waits `drt` clock cycles, then drives one output pulse of programmable width toward the optical driver. A hold-off period follows, and a completion strobe is raised. Triggers that arrive while a sequence is running are dropped and flagged.

## Interface
Parameters:
- HOLDOFF, 16: idle cycles after the pulse falls before a new trigger is accepted; 0 is legal.
- CNT_W, 32: width of the delay counter; must be ≥ 8.

Ports:
- clk_gen  in  1  generator clock; all state changes on its rising edge.
- rst  in  1  reset; asynchronous, active-high (one clock, async active-high reset).
- en  in  1  global enable; when 0, triggers are ignored and any running sequence is aborted.
- trig  in  1  external trigger, asynchronous to clk_gen.
- drt  in  CNT_W  delay in clk_gen cycles, from the RAM stage.
- width  in  8  pulse width in clk_gen cycles, from the RAM stage `out[7:0]`.
- pulse  out  1  generated synchronizing pulse, registered.
- busy  out  1  1 in any state other than IDLE.
- done  out  1  one-cycle strobe when a sequence returns to IDLE normally.
- missed  out  1  sticky flag: a trigger edge was dropped while busy; cleared only by rst.

## Operation
- Synchronizer: `trig` passes through a 2-flop synchronizer (s1, s2), then a third flop s3. The trigger edge is `trig_edge = s2 & ~s3`.
- FSM states: IDLE, DELAY, PULSE, HOLD.
- IDLE, on `trig_edge & en`:
  - Latch `drt` into D and `width` into W. Later changes on the inputs do not affect a running sequence.
  - If D ≠ 0: go to DELAY with cnt = D−1.
  - If D = 0 and W ≠ 0: go to PULSE with cnt = W−1 and pulse = 1.
  - If D = 0 and W = 0: go to HOLD.
- DELAY: if cnt = 0, go to PULSE (same W rules as above); otherwise decrement cnt.
- PULSE: pulse = 1. If cnt = 0, set pulse = 0 and go to HOLD, or straight to IDLE when HOLDOFF = 0. Otherwise decrement cnt.
- W = 0 means no pulse: the sequence goes from DELAY directly to HOLD with pulse held at 0.
- HOLD: runs for HOLDOFF cycles, then goes to IDLE.
- done is 1 for exactly the one cycle after the FSM enters IDLE from PULSE or HOLD.
- A `trig_edge` seen in any state other than IDLE is ignored and sets missed = 1. A trigger edge that coincides with the IDLE-entry edge is also dropped and flagged.
- en = 0: at the next edge the FSM goes to IDLE and pulse goes to 0. done is not asserted. The synchronizer keeps running.
- Arithmetic: cnt is CNT_W bits and unsigned. The maximum delay is 2^CNT_W − 1 cycles; there is no wrap-around.

## Timing
- Reset: while rst = 1, all of the following hold immediately and asynchronously:
  - pulse = 0, busy = 0, done = 0, missed = 0
  - state = IDLE, cnt = 0
  - s1 = s2 = s3 = 0
- Trigger latency: let E0 be the first clk_gen edge that samples trig = 1. The FSM leaves IDLE at edge T = E0+2.
- Pulse position: pulse rises at edge T+D and falls at edge T+D+W. It is high for exactly W cycles.
- busy rises at T. With HOLDOFF = H, busy falls at edge T+D+W+H, and done is high for the following cycle.
- Minimum trig high time is one clk_gen period. trig must be low for at least 2 cycles before it can re-arm an edge.
- rst asserted mid-sequence: pulse drops without waiting for a clock edge, and no done is produced.

## Test plan
- drt = 5, width = 3, HOLDOFF = 16, trig high at E0:
  - pulse is high on edges E0+7 through E0+9 and low at E0+10.
  - busy falls at E0+26, and done is 1 for one cycle after that.
- drt = 0, width = 1: pulse is high for exactly one cycle starting at E0+2, and missed stays 0.
- drt = 4, width = 0: pulse never goes high, busy spans 4+16 cycles from T, and done still fires.
- drt = 100, width = 10, second trig edge during DELAY: the second edge is ignored, the pulse timing follows the first trigger only, missed = 1 and stays 1 until rst.
- drt = 1000, width = 50, en dropped 20 cycles into PULSE: pulse is 0 at the next edge, busy = 0, done stays 0. A new trigger with en = 1 is accepted normally.
- rst asserted for 2 cycles in the middle of DELAY (drt = 200): all outputs are 0 asynchronously. A retrigger after rst is released gives full timing measured from the new E0.
